// File: rtl/skew_tile_buffer_pkg.sv
// Shared definitions for the skew tile buffer: drain FSM state encoding and
// the number of enabled beats needed to drain one skewed tile.
package skew_tile_buffer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

  function automatic int drain_len(input int tile_depth, input int array_size);
    return tile_depth + array_size - 1;
  endfunction

endpackage

// File: rtl/skew_tile_bank.sv
// One TILE_DEPTH x ARRAY_SIZE tile bank: whole-row synchronous write, per-lane
// combinational read where every lane addresses its own row.
module skew_tile_bank
  import skew_tile_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_SIZE = 4,
  parameter int TILE_DEPTH = 4,
  parameter int ROW_W      = 2
) (
  input  logic                                 clk,
  input  logic                                 wr_en_i,
  input  logic [ROW_W-1:0]                     wr_row_i,
  input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] wr_dat_i,
  input  logic [ARRAY_SIZE-1:0][ROW_W-1:0]      rd_row_i,
  output logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] rd_dat_o
);

  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] mem_q [TILE_DEPTH];

  // Rows beyond TILE_DEPTH are unreachable when the depth is not a power of two.
  always_ff @(posedge clk) begin
    if (wr_en_i && (int'(wr_row_i) < TILE_DEPTH)) begin
      mem_q[wr_row_i] <= wr_dat_i;
    end
  end

  always_comb begin
    rd_dat_o = '0;
    for (int j = 0; j < ARRAY_SIZE; j++) begin
      if (int'(rd_row_i[j]) < TILE_DEPTH) begin
        rd_dat_o[j] = mem_q[rd_row_i[j]][j];
      end
    end
  end

endmodule

// File: rtl/skew_tile_buffer.sv
// Ping-pong tile buffer feeding a systolic edge: fills one bank by rows while the other drains diagonally skewed.
// Optional SKEW_TILE_BUFFER_ERR_EN adds a sticky err_overflow flag for writes/commits refused while wr_ready=0.
module skew_tile_buffer
  import skew_tile_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_SIZE = 4,
  parameter int TILE_DEPTH = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        write,
  input  logic [((TILE_DEPTH > 1) ? $clog2(TILE_DEPTH) : 1)-1:0] row_ptr,
  input  logic                                        commit,
  input  logic signed [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] data_in,
  input  logic                                        enable,
  output logic                                        wr_ready,
  output logic signed [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] data_out,
  output logic                                        out_valid,
  output logic                                        drain_done
`ifdef SKEW_TILE_BUFFER_ERR_EN
  ,
  output logic                                        err_overflow
`endif
);

  localparam int ROW_W     = (TILE_DEPTH > 1) ? $clog2(TILE_DEPTH) : 1;
  localparam int DRAIN_LEN = drain_len(TILE_DEPTH, ARRAY_SIZE);
  localparam int T_W       = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;

  typedef logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] row_t;

  drain_state_e state_q, state_d;
  logic [T_W-1:0] t_q, t_d;
  logic           fill_ptr_q, fill_ptr_d;
  logic           drain_ptr_q, drain_ptr_d;
  logic [1:0]     full_q, full_d;
  row_t           data_out_q, data_out_d;
  logic           out_valid_q, out_valid_d;
  logic           drain_done_q, drain_done_d;

  logic                              commit_acc;
  logic [1:0]                        bank_wr_en;
  row_t                              bank_rd [2];
  row_t                              drain_dat;
  int                                lane_diff [ARRAY_SIZE];
  logic [ARRAY_SIZE-1:0]             lane_ok;
  logic [ARRAY_SIZE-1:0][ROW_W-1:0]  rd_row;

  assign wr_ready   = ~full_q[fill_ptr_q];
  assign commit_acc = commit & wr_ready;
  assign bank_wr_en = {write & wr_ready & fill_ptr_q, write & wr_ready & ~fill_ptr_q};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    skew_tile_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .ARRAY_SIZE(ARRAY_SIZE),
      .TILE_DEPTH(TILE_DEPTH),
      .ROW_W     (ROW_W)
    ) u_bank (
      .clk     (clk),
      .wr_en_i (bank_wr_en[b]),
      .wr_row_i(row_ptr),
      .wr_dat_i(data_in),
      .rd_row_i(rd_row),
      .rd_dat_o(bank_rd[b])
    );
  end

  assign drain_dat = bank_rd[drain_ptr_q];

  // Lane j lags lane 0 by j beats, so it reads row t-j of the draining tile.
  always_comb begin
    for (int j = 0; j < ARRAY_SIZE; j++) begin
      lane_diff[j] = int'(t_q) - j;
      lane_ok[j]   = (lane_diff[j] >= 0) && (lane_diff[j] < TILE_DEPTH);
      rd_row[j]    = lane_diff[j][ROW_W-1:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    t_d          = t_q;
    fill_ptr_d   = fill_ptr_q;
    drain_ptr_d  = drain_ptr_q;
    full_d       = full_q;
    data_out_d   = data_out_q;
    out_valid_d  = 1'b0;
    drain_done_d = 1'b0;

    if (commit_acc) begin
      full_d[fill_ptr_q] = 1'b1;
      fill_ptr_d         = ~fill_ptr_q;
    end

    case (state_q)
      IDLE: begin
        data_out_d = '0;
        if (enable && full_q[drain_ptr_q]) begin
          state_d = DRAIN;
          t_d     = '0;
        end
      end
      DRAIN: begin
        if (enable) begin
          for (int j = 0; j < ARRAY_SIZE; j++) begin
            data_out_d[j] = lane_ok[j] ? drain_dat[j] : '0;
          end
          out_valid_d = 1'b1;
          t_d         = t_q + T_W'(1);
          if (t_q == T_W'(DRAIN_LEN - 1)) begin
            drain_done_d        = 1'b1;
            full_d[drain_ptr_q] = 1'b0;
            drain_ptr_d         = ~drain_ptr_q;
            t_d                 = '0;
            // full_d already includes a commit landing on this same edge.
            if (!full_d[~drain_ptr_q]) begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      t_q          <= '0;
      fill_ptr_q   <= 1'b0;
      drain_ptr_q  <= 1'b0;
      full_q       <= '0;
      data_out_q   <= '0;
      out_valid_q  <= 1'b0;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      t_q          <= t_d;
      fill_ptr_q   <= fill_ptr_d;
      drain_ptr_q  <= drain_ptr_d;
      full_q       <= full_d;
      data_out_q   <= data_out_d;
      out_valid_q  <= out_valid_d;
      drain_done_q <= drain_done_d;
    end
  end

  assign data_out   = data_out_q;
  assign out_valid  = out_valid_q;
  assign drain_done = drain_done_q;

`ifdef SKEW_TILE_BUFFER_ERR_EN
  logic err_q, err_d;

  assign err_d = err_q | ((write | commit) & ~wr_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_overflow = err_q;
`endif

endmodule

// File: tb/tb_skew_tile_buffer.sv
// Directed and randomized bench for skew_tile_buffer; expected outputs come from a
// queue-of-tiles reference model that computes each skewed beat arithmetically.
module tb_skew_tile_buffer;

  localparam int DW  = 8;
  localparam int AS  = 4;
  localparam int TD  = 4;
  localparam int RW  = 2;
  localparam int LEN = TD + AS - 1;

  typedef logic [AS-1:0][DW-1:0] row_t;
  typedef row_t [TD-1:0]         tile_t;

  logic          clk = 1'b0;
  logic          rst, write, commit, enable;
  logic [RW-1:0] row_ptr;
  row_t          data_in;
  logic          wr_ready, out_valid, drain_done;
  row_t          data_out;
`ifdef SKEW_TILE_BUFFER_ERR_EN
  logic          err_overflow;
`endif

  always #5 clk = ~clk;

  skew_tile_buffer #(.DATA_WIDTH(DW), .ARRAY_SIZE(AS), .TILE_DEPTH(TD)) dut (
    .clk       (clk),
    .rst       (rst),
    .write     (write),
    .row_ptr   (row_ptr),
    .commit    (commit),
    .data_in   (data_in),
    .enable    (enable),
    .wr_ready  (wr_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .drain_done(drain_done)
`ifdef SKEW_TILE_BUFFER_ERR_EN
    ,
    .err_overflow(err_overflow)
`endif
  );

  // Reference model: committed tiles wait in order; the head one is drained.
  tile_t m_fill;
  tile_t m_pend[$];
  bit    m_active;
  int    m_t;
  row_t  m_dout;
  bit    m_vld, m_done, m_err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] spec_beat [LEN] = '{32'h0000_0000, 32'h0000_0104, 32'h0002_0508, 32'h0306_090C,
                                   32'h070A_0D00, 32'h0B0E_0000, 32'h0F00_0000};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic row_t ramp_row(input int i);
    row_t r;
    for (int j = 0; j < AS; j++) r[j] = DW'(j + 4 * i);
    return r;
  endfunction

  function automatic row_t flat_row(input int v);
    row_t r;
    for (int j = 0; j < AS; j++) r[j] = DW'(v);
    return r;
  endfunction

  task automatic model_edge(input bit w, input logic [RW-1:0] r, input bit c, input row_t d,
                            input bit en, input bit rs);
    bit ready, cacc;
    int k;
    if (rs) begin
      m_pend.delete();
      m_active = 0; m_t = 0; m_dout = '0; m_vld = 0; m_done = 0; m_err = 0;
      return;
    end
    ready = (m_pend.size() < 2);
    cacc  = c && ready;
    if ((w || c) && !ready) m_err = 1;
    if (w && ready) m_fill[r] = d;
    m_vld  = 0;
    m_done = 0;
    if (!m_active) begin
      m_dout = '0;
      if (en && m_pend.size() > 0) begin
        m_active = 1;
        m_t      = 0;
      end
    end else if (en) begin
      for (int j = 0; j < AS; j++) begin
        k = m_t - j;
        m_dout[j] = (k >= 0 && k < TD) ? m_pend[0][k][j] : '0;
      end
      m_vld = 1;
      m_t++;
      if (m_t == LEN) begin
        m_done = 1;
        void'(m_pend.pop_front());
        m_t      = 0;
        m_active = (m_pend.size() > 0) || cacc;
      end
    end
    if (cacc) m_pend.push_back(m_fill);
  endtask

  task automatic check_outputs();
    chk("data_out", data_out, m_dout);
    chk("out_valid", out_valid, m_vld);
    chk("drain_done", drain_done, m_done);
    chk("wr_ready", wr_ready, m_pend.size() < 2);
`ifdef SKEW_TILE_BUFFER_ERR_EN
    chk("err_overflow", err_overflow, m_err);
`endif
  endtask

  task automatic cyc(input bit w, input logic [RW-1:0] r, input bit c, input row_t d, input bit en);
    rst = 0; write = w; row_ptr = r; commit = c; data_in = d; enable = en;
    @(posedge clk);
    model_edge(w, r, c, d, en, 1'b0);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1; write = 0; commit = 0; enable = 0; row_ptr = '0; data_in = '0;
    @(posedge clk);
    model_edge(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    #1;
    rst = 0;
    chk("rst_data_out", data_out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_drain_done", drain_done, 0);
    chk("rst_wr_ready", wr_ready, 1);
`ifdef SKEW_TILE_BUFFER_ERR_EN
    chk("rst_err", err_overflow, 0);
`endif
  endtask

  task automatic load_ramp(input bit en);
    for (int i = 0; i < TD; i++) cyc(1'b1, RW'(i), i == TD - 1, ramp_row(i), en);
  endtask

  initial begin
    int nb, first, last, ndone;
    logic [TD-1:0] mask, mask_now;
    bit w, c, en, rdy;
    logic [RW-1:0] r;
    row_t d;

    m_fill = '0;
    do_reset();

    // Basic skewed drain of a ramp tile.
    load_ramp(1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b1);
    chk("t1_start_valid", out_valid, 0);
    for (int b = 0; b < LEN; b++) begin
      cyc(1'b0, '0, 1'b0, '0, 1'b1);
      chk("t1_beat", data_out, spec_beat[b]);
      chk("t1_done", drain_done, b == LEN - 1);
      chk("t1_wr_ready", wr_ready, 1);
    end
    cyc(1'b0, '0, 1'b0, '0, 1'b0);
    chk("t1_idle_zero", data_out, 0);

    // Stall for two cycles after beat 2.
    load_ramp(1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b1);
    for (int b = 0; b < 3; b++) cyc(1'b0, '0, 1'b0, '0, 1'b1);
    for (int s = 0; s < 2; s++) begin
      cyc(1'b0, '0, 1'b0, '0, 1'b0);
      chk("t2_hold", data_out, 32'h0002_0508);
      chk("t2_stall_valid", out_valid, 0);
    end
    cyc(1'b0, '0, 1'b0, '0, 1'b1);
    chk("t2_resume", data_out, 32'h0306_090C);
    for (int b = 4; b < LEN; b++) cyc(1'b0, '0, 1'b0, '0, 1'b1);
    chk("t2_done", drain_done, 1);

    // Two full banks, refused third write, back-to-back drain.
    for (int i = 0; i < TD; i++) cyc(1'b1, RW'(i), i == TD - 1, flat_row(1), 1'b0);
    for (int i = 0; i < TD; i++) cyc(1'b1, RW'(i), i == TD - 1, flat_row(2), 1'b0);
    chk("t3_full", wr_ready, 0);
    cyc(1'b1, '0, 1'b0, flat_row(99), 1'b0);
    chk("t3_still_full", wr_ready, 0);
`ifdef SKEW_TILE_BUFFER_ERR_EN
    chk("t3_err", err_overflow, 1);
`endif
    nb = 0; first = -1; last = -1; ndone = 0;
    for (int k = 0; k < 2 * LEN + 4; k++) begin
      cyc(1'b0, '0, 1'b0, '0, 1'b1);
      if (out_valid) begin
        nb++;
        if (first < 0) first = k;
        last = k;
      end
      if (drain_done) ndone++;
    end
    chk("t3_beats", nb, 2 * LEN);
    chk("t3_contig", last - first + 1, 2 * LEN);
    chk("t3_dones", ndone, 2);

    // Reset in the middle of a drain.
    load_ramp(1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b1);
    for (int b = 0; b < 4; b++) cyc(1'b0, '0, 1'b0, '0, 1'b1);
    chk("t4_beat3", data_out, spec_beat[3]);
    do_reset();
    ndone = 0;
    for (int k = 0; k < LEN + 2; k++) begin
      cyc(1'b0, '0, 1'b0, '0, 1'b1);
      if (drain_done) ndone++;
    end
    chk("t4_no_done", ndone, 0);

    // Commit lands on the same edge as the opposite bank's final beat.
    load_ramp(1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b1);
    for (int k = 1; k <= LEN; k++) begin
      if (k >= LEN - TD + 1) cyc(1'b1, RW'(k - (LEN - TD + 1)), k == LEN, flat_row(k), 1'b1);
      else cyc(1'b0, '0, 1'b0, '0, 1'b1);
    end
    chk("t5_done", drain_done, 1);
    cyc(1'b0, '0, 1'b0, '0, 1'b1);
    chk("t5_no_bubble", out_valid, 1);
    for (int k = 1; k < LEN; k++) cyc(1'b0, '0, 1'b0, '0, 1'b1);
    chk("t5_second_done", drain_done, 1);

    // Randomized traffic; tiles are only committed once every row has been written.
    mask = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        mask = '0;
        continue;
      end
      rdy = (m_pend.size() < 2);
      w   = ($urandom_range(0, 2) != 0);
      r   = RW'($urandom_range(0, TD - 1));
      d   = row_t'($urandom());
      en  = ($urandom_range(0, 9) < 7);
      mask_now = mask;
      if (w && rdy) mask_now[r] = 1'b1;
      c = rdy ? ((&mask_now) && ($urandom_range(0, 2) == 0)) : ($urandom_range(0, 7) == 0);
      cyc(w, r, c, d, en);
      mask = (c && rdy) ? '0 : mask_now;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
